cpu_read_con: RTL and testbench

CPU readback and status block for the MAC/SDRAM/SOURCE datapath; the read-side counterpart of the CPU write control bank on the same 9-bit CPU bus. It returns registered 32-bit read data for CPU reads and keeps sticky event flags and saturating event counters, both cleared on read. Sits beside the write control bank; status inputs come from the MAC, SDRAM and SOURCE sub-blocks in the same clock domain.

---
 rtl/cpu_read_pkg.sv | 54 +++++
 rtl/cpu_read_con_evt_counter.sv | 43 ++++
 rtl/cpu_read_con.sv | 190 +++++++++++++++++++
 tb/tb_cpu_read_con.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_read_pkg.sv
// Shared definitions for the CPU readback/status block: address map,
// version constant, counter width and status/sticky bit positions.
package cpu_read_pkg;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 32;

   // CPU word addresses of the readback map
   localparam logic [ADDR_W-1:0] ADDR_STATUS    = 9'd1;
   localparam logic [ADDR_W-1:0] ADDR_STICKY    = 9'd2;
   localparam logic [ADDR_W-1:0] ADDR_MAC_CNT   = 9'd3;
   localparam logic [ADDR_W-1:0] ADDR_WRADDR    = 9'd4;
   localparam logic [ADDR_W-1:0] ADDR_RDADDR    = 9'd5;
   localparam logic [ADDR_W-1:0] ADDR_SRC_CNT   = 9'd20;
   localparam logic [ADDR_W-1:0] ADDR_USEDW     = 9'd21;
   localparam logic [ADDR_W-1:0] ADDR_VERSION   = 9'd30;
   localparam logic [ADDR_W-1:0] ADDR_DBG_CYC   = 9'd31;
   localparam logic [ADDR_W-1:0] ADDR_DBG_OVFTS = 9'd32;

   localparam logic [DATA_W-1:0] VERSION = 32'h5344_0100;

   // Level status word bit positions (address 1)
   localparam int unsigned STAT_MAC_BUSY_BIT = 0;
   localparam int unsigned STAT_OVF_SEEN_BIT = 1;
   localparam int unsigned STAT_SRC_BUSY_BIT = 2;

   // Sticky event word bit positions (address 2)
   localparam int unsigned STK_TX_DONE_BIT = 0;
   localparam int unsigned STK_WR_DONE_BIT = 1;
   localparam int unsigned STK_RD_DONE_BIT = 2;
   localparam int unsigned STK_OVF_BIT     = 3;
   localparam int unsigned STK_W           = 4;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Sticky update: a clear wipes the old bits, but events in the same
   // cycle are OR-ed in afterwards so they are never lost.
   function automatic logic [STK_W-1:0] sticky_update(
      input logic [STK_W-1:0] cur,
      input logic             clr,
      input logic [STK_W-1:0] set
   );
      logic [STK_W-1:0] base;
      if (clr) begin
         base = {STK_W{1'b0}};
      end else begin
         base = cur;
      end
      return base | set;
   endfunction

endpackage

// File: rtl/cpu_read_con_evt_counter.sv
// Saturating event counter with clear. A clear and an increment in the
// same cycle leave the counter at 1 so the coincident event is kept.
module evt_counter
   import cpu_read_pkg::*;
(
   input  logic             clk,
   input  logic             nRST,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;

   // Next count: clear has priority over the old value, event wins over clear
   always_comb begin
      cnt_next_s = cnt_r;
      if (clr) begin
         if (inc) begin
            cnt_next_s = CNT_ONE;
         end else begin
            cnt_next_s = {CNT_W{1'b0}};
         end
      end else if (inc && (cnt_r != CNT_MAX)) begin
         cnt_next_s = cnt_r + CNT_ONE;
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

   assign count = cnt_r;

endmodule

// File: rtl/cpu_read_con.sv
// CPU readback and status block. Detects a new read strobe, returns the
// addressed word one cycle after acceptance and maintains clear-on-read
// sticky flags and saturating event counters.
// Optional feature macro: CPU_RD_DEBUG_EN adds a free-running cycle counter
// (address 31) and an overflow timestamp (address 32).
module cpu_read_con
   import cpu_read_pkg::*;
(
   input  logic              clk,
   input  logic              nRST,
   input  logic              cpu_rd_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rdata_valid,
   input  logic              mac_busy,
   input  logic              mac_tx_done,
   input  logic              sdram_wr_done,
   input  logic              sdram_rd_done,
   input  logic              sdram_fifo_ovf,
   input  logic [15:0]       sdram_wraddr_cur,
   input  logic [15:0]       sdram_rdaddr_cur,
   input  logic              source_busy,
   input  logic              source_frame_done,
   input  logic [15:0]       source_fifo_usedw
);

   // Strobe history: rd_n_r holds the strobe sampled at the last edge,
   // rd_n_prev_r the one before. Both reset high so a strobe already low
   // at reset release is accepted exactly once.
   logic              rd_n_r;
   logic              rd_n_prev_r;
   logic [ADDR_W-1:0] addr_r;
   logic              accept_s;

   logic [STK_W-1:0]  sticky_r;
   logic [STK_W-1:0]  sticky_set_s;
   logic [STK_W-1:0]  sticky_next_s;
   logic              sticky_clr_s;
   logic              ovf_seen_r;

   logic              mac_clr_s;
   logic              src_clr_s;
   logic [CNT_W-1:0]  mac_cnt_s;
   logic [CNT_W-1:0]  src_cnt_s;

   logic [DATA_W-1:0] rd_mux_s;
   logic [DATA_W-1:0] rdata_r;
   logic              rdata_valid_r;

`ifdef CPU_RD_DEBUG_EN
   logic [DATA_W-1:0] cyc_cnt_r;
   logic [DATA_W-1:0] ovf_ts_r;
`endif

   // Strobe and address sampling
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         rd_n_r      <= 1'b1;
         rd_n_prev_r <= 1'b1;
         addr_r      <= {ADDR_W{1'b0}};
      end else begin
         rd_n_r      <= cpu_rd_n;
         rd_n_prev_r <= rd_n_r;
         addr_r      <= cpu_addr;
      end
   end

   // One accept per low period: strobe newly seen low at the last edge
   assign accept_s = (~rd_n_r) & rd_n_prev_r;

   // Clear-on-read decode for the accepted address
   always_comb begin
      sticky_clr_s = 1'b0;
      mac_clr_s    = 1'b0;
      src_clr_s    = 1'b0;
      if (accept_s) begin
         case (addr_r)
            ADDR_STICKY:  sticky_clr_s = 1'b1;
            ADDR_MAC_CNT: mac_clr_s    = 1'b1;
            ADDR_SRC_CNT: src_clr_s    = 1'b1;
            default: begin
               sticky_clr_s = 1'b0;
               mac_clr_s    = 1'b0;
               src_clr_s    = 1'b0;
            end
         endcase
      end else begin
         sticky_clr_s = 1'b0;
         mac_clr_s    = 1'b0;
         src_clr_s    = 1'b0;
      end
   end

   // Gather the event pulses feeding the sticky flags
   always_comb begin
      sticky_set_s                  = {STK_W{1'b0}};
      sticky_set_s[STK_TX_DONE_BIT] = mac_tx_done;
      sticky_set_s[STK_WR_DONE_BIT] = sdram_wr_done;
      sticky_set_s[STK_RD_DONE_BIT] = sdram_rd_done;
      sticky_set_s[STK_OVF_BIT]     = sdram_fifo_ovf;
      sticky_next_s = sticky_update(sticky_r, sticky_clr_s, sticky_set_s);
   end

   // Sticky flags and the reset-only overflow-seen flag
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         sticky_r   <= {STK_W{1'b0}};
         ovf_seen_r <= 1'b0;
      end else begin
         sticky_r   <= sticky_next_s;
         ovf_seen_r <= ovf_seen_r | sdram_fifo_ovf;
      end
   end

   evt_counter u_mac_cnt (
      .clk   (clk),
      .nRST  (nRST),
      .inc   (mac_tx_done),
      .clr   (mac_clr_s),
      .count (mac_cnt_s)
   );

   evt_counter u_src_cnt (
      .clk   (clk),
      .nRST  (nRST),
      .inc   (source_frame_done),
      .clr   (src_clr_s),
      .count (src_cnt_s)
   );

`ifdef CPU_RD_DEBUG_EN
   // Free-running cycle counter and timestamp of the latest overflow
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         cyc_cnt_r <= 32'd0;
         ovf_ts_r  <= 32'd0;
      end else begin
         cyc_cnt_r <= cyc_cnt_r + 32'd1;
         if (sdram_fifo_ovf) begin
            ovf_ts_r <= cyc_cnt_r;
         end else begin
            ovf_ts_r <= ovf_ts_r;
         end
      end
   end
`endif

   // Read mux: pre-clear values and levels as seen in the accept cycle
   always_comb begin
      rd_mux_s = 32'd0;
      case (addr_r)
         ADDR_STATUS: begin
            rd_mux_s                    = 32'd0;
            rd_mux_s[STAT_MAC_BUSY_BIT] = mac_busy;
            rd_mux_s[STAT_OVF_SEEN_BIT] = ovf_seen_r;
            rd_mux_s[STAT_SRC_BUSY_BIT] = source_busy;
         end
         ADDR_STICKY:    rd_mux_s = {28'd0, sticky_r};
         ADDR_MAC_CNT:   rd_mux_s = mac_cnt_s;
         ADDR_WRADDR:    rd_mux_s = {16'd0, sdram_wraddr_cur};
         ADDR_RDADDR:    rd_mux_s = {16'd0, sdram_rdaddr_cur};
         ADDR_SRC_CNT:   rd_mux_s = src_cnt_s;
         ADDR_USEDW:     rd_mux_s = {16'd0, source_fifo_usedw};
         ADDR_VERSION:   rd_mux_s = VERSION;
`ifdef CPU_RD_DEBUG_EN
         ADDR_DBG_CYC:   rd_mux_s = cyc_cnt_r;
         ADDR_DBG_OVFTS: rd_mux_s = ovf_ts_r;
`endif
         default:        rd_mux_s = 32'd0;
      endcase
   end

   // Read data capture: update and pulse valid on accept, otherwise hold
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         rdata_r       <= 32'd0;
         rdata_valid_r <= 1'b0;
      end else if (accept_s) begin
         rdata_r       <= rd_mux_s;
         rdata_valid_r <= 1'b1;
      end else begin
         rdata_r       <= rdata_r;
         rdata_valid_r <= 1'b0;
      end
   end

   assign cpu_rdata       = rdata_r;
   assign cpu_rdata_valid = rdata_valid_r;

endmodule

// File: tb/tb_cpu_read_con.sv
// Scoreboard bench for cpu_read_con: a behavioural model predicts each read
// result when the read is accepted; a monitor compares on every valid pulse.
module tb_cpu_read_con;

   logic        clk = 1'b0;
   logic        nRST;
   logic        cpu_rd_n;
   logic [8:0]  cpu_addr;
   logic [31:0] cpu_rdata;
   logic        cpu_rdata_valid;
   logic        mac_busy, mac_tx_done, sdram_wr_done, sdram_rd_done, sdram_fifo_ovf;
   logic [15:0] sdram_wraddr_cur, sdram_rdaddr_cur, source_fifo_usedw;
   logic        source_busy, source_frame_done;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];

   // Reference model state
   logic        m_prev1, m_prev2;
   logic [8:0]  m_addr1;
   logic [31:0] m_mac, m_src, m_cyc, m_ts;
   logic        m_tx, m_wr, m_rd, m_ovf, m_ovf_seen;

   cpu_read_con dut (
      .clk(clk), .nRST(nRST), .cpu_rd_n(cpu_rd_n), .cpu_addr(cpu_addr),
      .cpu_rdata(cpu_rdata), .cpu_rdata_valid(cpu_rdata_valid),
      .mac_busy(mac_busy), .mac_tx_done(mac_tx_done),
      .sdram_wr_done(sdram_wr_done), .sdram_rd_done(sdram_rd_done),
      .sdram_fifo_ovf(sdram_fifo_ovf), .sdram_wraddr_cur(sdram_wraddr_cur),
      .sdram_rdaddr_cur(sdram_rdaddr_cur), .source_busy(source_busy),
      .source_frame_done(source_frame_done), .source_fifo_usedw(source_fifo_usedw)
   );

   always #5 clk = ~clk;

   // Monitor: every valid pulse must match the oldest predicted read
   always @(negedge clk) begin
      if (nRST && cpu_rdata_valid) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid: got rdata=%h with valid, required no valid pulse", cpu_rdata);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (cpu_rdata !== e) begin
               fails++;
               $display("FAIL read_data: got %h, required %h", cpu_rdata, e);
            end
         end
      end
   end

   function automatic logic [31:0] model_read(input logic [8:0] a);
      case (a)
         9'd1:  return {29'd0, source_busy, m_ovf_seen, mac_busy};
         9'd2:  return {28'd0, m_ovf, m_rd, m_wr, m_tx};
         9'd3:  return m_mac;
         9'd4:  return {16'd0, sdram_wraddr_cur};
         9'd5:  return {16'd0, sdram_rdaddr_cur};
         9'd20: return m_src;
         9'd21: return {16'd0, source_fifo_usedw};
         9'd30: return 32'h5344_0100;
`ifdef CPU_RD_DEBUG_EN
         9'd31: return m_cyc;
         9'd32: return m_ts;
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_prev1 = 1'b1; m_prev2 = 1'b1; m_addr1 = 9'd0;
      m_mac = 32'd0; m_src = 32'd0; m_cyc = 32'd0; m_ts = 32'd0;
      m_tx = 1'b0; m_wr = 1'b0; m_rd = 1'b0; m_ovf = 1'b0; m_ovf_seen = 1'b0;
      exp_q.delete();
   endtask

   // One clock cycle of the model using the inputs currently applied.
   // A read is accepted in the cycle after the strobe is first seen low;
   // the returned value is the state before this cycle's clear and events.
   task automatic model_step();
      if (!m_prev1 && m_prev2) begin
         exp_q.push_back(model_read(m_addr1));
         if (m_addr1 == 9'd2) begin
            m_tx = 1'b0; m_wr = 1'b0; m_rd = 1'b0; m_ovf = 1'b0;
         end
         if (m_addr1 == 9'd3)  m_mac = 32'd0;
         if (m_addr1 == 9'd20) m_src = 32'd0;
      end
      if (mac_tx_done) begin
         m_tx = 1'b1;
         if (m_mac != 32'hFFFF_FFFF) m_mac = m_mac + 32'd1;
      end
      if (source_frame_done && m_src != 32'hFFFF_FFFF) m_src = m_src + 32'd1;
      if (sdram_wr_done) m_wr = 1'b1;
      if (sdram_rd_done) m_rd = 1'b1;
      if (sdram_fifo_ovf) begin
         m_ovf = 1'b1; m_ovf_seen = 1'b1; m_ts = m_cyc;
      end
      m_cyc   = m_cyc + 32'd1;
      m_prev2 = m_prev1;
      m_prev1 = cpu_rd_n;
      m_addr1 = cpu_addr;
   endtask

   // Advance one cycle; pulses last exactly one cycle
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      mac_tx_done = 1'b0; sdram_wr_done = 1'b0; sdram_rd_done = 1'b0;
      sdram_fifo_ovf = 1'b0; source_frame_done = 1'b0;
   endtask

   task automatic do_read(input logic [8:0] a, input int hold);
      cpu_rd_n = 1'b0;
      cpu_addr = a;
      repeat (hold) step();
      cpu_rd_n = 1'b1;
      step();
      step();
   endtask

   initial begin
      nRST = 1'b0; cpu_rd_n = 1'b1; cpu_addr = 9'd0;
      mac_busy = 1'b0; mac_tx_done = 1'b0; sdram_wr_done = 1'b0; sdram_rd_done = 1'b0;
      sdram_fifo_ovf = 1'b0; sdram_wraddr_cur = 16'h1234; sdram_rdaddr_cur = 16'hABCD;
      source_busy = 1'b0; source_frame_done = 1'b0; source_fifo_usedw = 16'd77;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (cpu_rdata !== 32'd0 || cpu_rdata_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got rdata=%h valid=%b, required 0/0", cpu_rdata, cpu_rdata_valid);
      end
      nRST = 1'b1;
      step();

      // Version, then mac packet counter clear-on-read
      do_read(9'd30, 2);
      repeat (5) begin mac_tx_done = 1'b1; step(); end
      do_read(9'd3, 2);
      do_read(9'd3, 2);

      // Strobe held low 10 cycles after 3 frames: single accept and clear
      repeat (3) begin source_frame_done = 1'b1; step(); end
      do_read(9'd20, 10);
      do_read(9'd20, 2);

      // Frame event in the very accept cycle of address 20 (count 7)
      repeat (7) begin source_frame_done = 1'b1; step(); end
      cpu_rd_n = 1'b0; cpu_addr = 9'd20;
      step();
      source_frame_done = 1'b1;
      step();
      cpu_rd_n = 1'b1;
      step(); step();
      do_read(9'd20, 2);

      // Saturation near the top of the counter range
      force dut.u_mac_cnt.cnt_r = 32'hFFFF_FFFE;
      #1;
      release dut.u_mac_cnt.cnt_r;
      m_mac = 32'hFFFF_FFFE;
      repeat (3) begin mac_tx_done = 1'b1; step(); end
      do_read(9'd3, 2);

      // Overflow sticky, clear-on-read, persistent ovf_seen, timestamp
      mac_busy = 1'b1;
      repeat (4) step();
      sdram_fifo_ovf = 1'b1; step();
      do_read(9'd2, 2);
      do_read(9'd2, 2);
      do_read(9'd1, 3);
      do_read(9'd32, 2);
      do_read(9'd31, 2);
      do_read(9'd4, 2);
      do_read(9'd21, 2);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         mac_tx_done       = ($urandom_range(0, 3) == 0);
         sdram_wr_done     = ($urandom_range(0, 4) == 0);
         sdram_rd_done     = ($urandom_range(0, 4) == 0);
         sdram_fifo_ovf    = ($urandom_range(0, 15) == 0);
         source_frame_done = ($urandom_range(0, 3) == 0);
         mac_busy          = $urandom_range(0, 1) == 1;
         source_busy       = $urandom_range(0, 1) == 1;
         sdram_wraddr_cur  = 16'($urandom);
         sdram_rdaddr_cur  = 16'($urandom);
         source_fifo_usedw = 16'($urandom);
         if (cpu_rd_n) begin
            if ($urandom_range(0, 3) == 0) begin
               logic [8:0] alist [13];
               alist = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd20, 9'd21, 9'd30,
                         9'd31, 9'd32, 9'd0, 9'd7, 9'd511};
               cpu_rd_n = 1'b0;
               cpu_addr = alist[$urandom_range(0, 12)];
            end
         end else if ($urandom_range(0, 2) == 0) begin
            cpu_rd_n = 1'b1;
         end
         step();
      end
      cpu_rd_n = 1'b1;
      repeat (3) step();

      // Reset in the middle of a read: abandoned, outputs cleared at once
      repeat (2) begin mac_tx_done = 1'b1; step(); end
      do_read(9'd30, 2);
      cpu_rd_n = 1'b0; cpu_addr = 9'd3;
      step();
      nRST = 1'b0;
      #1;
      tests++;
      if (cpu_rdata !== 32'd0 || cpu_rdata_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_read: got rdata=%h valid=%b, required 0/0", cpu_rdata, cpu_rdata_valid);
      end
      @(posedge clk);
      #1;
      model_reset();
      nRST = 1'b1;
      step(); step();
      cpu_rd_n = 1'b1;
      step(); step();
      do_read(9'd2, 2);

      // Every predicted read must have been delivered
      repeat (4) step();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL missing_valid: got %0d undelivered reads, required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
